// File: rtl/coh_noc_pkg.sv
// Shared coherent-NoC types: channel encodings, crosspoint defaults and the flit container.
package coh_noc_pkg;

  typedef enum logic [1:0] {
    CH_REQ = 2'b00,
    CH_RSP = 2'b01,
    CH_DAT = 2'b10,
    CH_SNP = 2'b11
  } ch_type_e;

  localparam int XP_NUM_VC   = 4;
  localparam int XP_VC_DEPTH = 4;
  localparam int FLIT_W      = 32;

  typedef struct packed {
    logic [7:0]  txn_id;
    logic [23:0] payload;
  } flit_fields_t;

  typedef union packed {
    logic [FLIT_W-1:0] raw;
    flit_fields_t      f;
  } flit_u;

endpackage

// File: rtl/xp_vc_fifo.sv
// Single-VC circular flit buffer; occupancy is registered so credit math never sees in_* combinationally.
module xp_vc_fifo
  import coh_noc_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH+1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  flit_u            wdata,
  input  logic             pop,
  output flit_u            head,
  output logic [CNT_W-1:0] occupancy
);

  flit_u            mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      case ({push, pop})
        2'b10:   occupancy <= occupancy + CNT_W'(1);
        2'b01:   occupancy <= occupancy - CNT_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/xp_vc_input_port.sv
// Crosspoint input port: per-VC credit-governed buffering, round-robin VC arbitration
// into a registered valid/ready output stage, one credit pulse per dequeued flit.
module xp_vc_input_port
  import coh_noc_pkg::*;
#(
  parameter  int         NUM_VC       = XP_NUM_VC,
  parameter  int         VC_DEPTH     = XP_VC_DEPTH,
  parameter  logic [1:0] CHANNEL_TYPE = CH_REQ,
  localparam int         VC_W         = $clog2(NUM_VC),
  localparam int         CNT_W        = $clog2(VC_DEPTH+1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  flit_u                   in_flit,
  input  logic [VC_W-1:0]         in_vc_id,
  input  logic [1:0]              in_channel_type,
  output logic [NUM_VC-1:0]       credit_return,
  output logic [NUM_VC*CNT_W-1:0] credit_count,
  output logic                    out_valid,
  input  logic                    out_ready,
  output flit_u                   out_flit,
  output logic [VC_W-1:0]         out_vc_id,
  output logic                    ovf_err,
  output logic                    type_err
);

  logic [NUM_VC-1:0][CNT_W-1:0] occ;
  flit_u                        head [NUM_VC];
  logic [NUM_VC-1:0]            push, pop, non_empty;
  logic                         vc_ok, accept, tgt_full, load, gnt_valid;
  logic [VC_W-1:0]              gnt, last_grant;

  // Out-of-range VC ids can only occur when NUM_VC is not a power of two.
  generate
    if ((1 << VC_W) == NUM_VC) begin : g_vc_full_range
      assign vc_ok = 1'b1;
    end else begin : g_vc_check
      assign vc_ok = (int'(in_vc_id) < NUM_VC);
    end
  endgenerate

  assign accept = in_valid && vc_ok && (in_channel_type == CHANNEL_TYPE);
  assign load   = !out_valid || out_ready;

  always_comb begin
    tgt_full = 1'b0;
    for (int v = 0; v < NUM_VC; v++)
      if (in_vc_id == VC_W'(v)) tgt_full = (occ[v] == CNT_W'(VC_DEPTH));
  end

  // Round-robin: first non-empty VC after last_grant, wrapping.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_valid = 1'b0;
    gnt       = '0;
    for (int i = 1; i <= NUM_VC; i++) begin
      idx = (int'(last_grant) + i) % NUM_VC;
      if (!gnt_valid && non_empty[idx]) begin
        gnt_valid = 1'b1;
        gnt       = VC_W'(idx);
      end
    end
  end

  generate
    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
      assign push[v]      = accept && !tgt_full && (in_vc_id == VC_W'(v));
      assign pop[v]       = load && gnt_valid && (gnt == VC_W'(v));
      assign non_empty[v] = (occ[v] != '0);
      assign credit_count[v*CNT_W +: CNT_W] = CNT_W'(VC_DEPTH) - occ[v];

      xp_vc_fifo #(.DEPTH(VC_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push[v]),
        .wdata     (in_flit),
        .pop       (pop[v]),
        .head      (head[v]),
        .occupancy (occ[v])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_flit      <= '0;
      out_vc_id     <= '0;
      last_grant    <= VC_W'(NUM_VC-1);
      credit_return <= '0;
      ovf_err       <= 1'b0;
      type_err      <= 1'b0;
    end else begin
      credit_return <= pop;
      if (load) begin
        out_valid <= gnt_valid;
        if (gnt_valid) begin
          out_flit   <= head[gnt];
          out_vc_id  <= gnt;
          last_grant <= gnt;
        end
      end
      if (in_valid && !accept)  type_err <= 1'b1;
      if (accept && tgt_full)   ovf_err  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_xp_vc_input_port.sv
// Directed bench for xp_vc_input_port: latency, round-robin order, overflow, type drop, stall, reset.
module tb_xp_vc_input_port;
  import coh_noc_pkg::*;

  localparam int NV = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  flit_u         in_flit;
  logic [1:0]    in_vc_id;
  logic [1:0]    in_channel_type;
  logic [NV-1:0] credit_return;
  logic [NV*CW-1:0] credit_count;
  logic          out_valid;
  logic          out_ready;
  flit_u         out_flit;
  logic [1:0]    out_vc_id;
  logic          ovf_err;
  logic          type_err;

  int total   = 0;
  int passed  = 0;
  int credits = 0;

  xp_vc_input_port dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_flit         (in_flit),
    .in_vc_id        (in_vc_id),
    .in_channel_type (in_channel_type),
    .credit_return   (credit_return),
    .credit_count    (credit_count),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_flit        (out_flit),
    .out_vc_id       (out_vc_id),
    .ovf_err         (ovf_err),
    .type_err        (type_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    credits += $countones(credit_return);
  endtask

  task automatic send(input logic [1:0] vc, input logic [1:0] ch, input logic [31:0] data);
    in_valid        = 1'b1;
    in_vc_id        = vc;
    in_channel_type = ch;
    in_flit.raw     = data;
    tick();
    in_valid        = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [CW-1:0] cc(input int v);
    return credit_count[v*CW +: CW];
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_flit = '0; in_vc_id = '0;
    in_channel_type = CH_REQ; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_flit", 64'(out_flit), 64'd0);
    chk("rst_credit_count", 64'(credit_count), 64'h924);
    chk("rst_credit_return", 64'(credit_return), 64'd0);
    chk("rst_errs", {62'd0, ovf_err, type_err}, 64'd0);

    // Single flit on VC2: out_valid and credit pulse two cycles after in_valid.
    credits = 0;
    send(2'd2, CH_REQ, 32'hA000_0002);
    chk("lat_c1_valid", 64'(out_valid), 64'd0);
    chk("lat_c1_cc2", 64'(cc(2)), 64'd3);
    tick();
    chk("lat_c2_valid", 64'(out_valid), 64'd1);
    chk("lat_c2_vc", 64'(out_vc_id), 64'd2);
    chk("lat_c2_flit", 64'(out_flit), 64'hA000_0002);
    chk("lat_c2_credit", 64'(credit_return), 64'b0100);
    chk("lat_c2_cc2", 64'(cc(2)), 64'd4);
    tick();
    chk("lat_c3_valid", 64'(out_valid), 64'd0);
    chk("lat_c3_credit", 64'(credit_return), 64'd0);

    // 16 flits interleaved across VCs while stalled, then drained round-robin.
    out_ready = 1'b0; credits = 0;
    for (int k = 0; k < 16; k++) send(2'(k % 4), CH_REQ, 32'hB000_0000 + 32'(k));
    chk("rr_held_vc", 64'(out_vc_id), 64'd0);
    chk("rr_cc0", 64'(cc(0)), 64'd1);
    chk("rr_cc1", 64'(cc(1)), 64'd0);
    chk("rr_cc3", 64'(cc(3)), 64'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("rr_valid", 64'(out_valid), 64'd1);
      chk("rr_vc", 64'(out_vc_id), 64'(k % 4));
      chk("rr_flit", 64'(out_flit), 64'hB000_0000 + 64'(k));
      tick();
    end
    chk("rr_drained", 64'(out_valid), 64'd0);
    chk("rr_credits", 64'(credits), 64'd16);

    // Overflow VC1 behind a flit parked in the output register.
    out_ready = 1'b0; credits = 0;
    send(2'd0, CH_REQ, 32'hC000_0000);
    for (int i = 0; i < 4; i++) send(2'd1, CH_REQ, 32'hC100_0000 + 32'(i));
    chk("ovf_cc1_full", 64'(cc(1)), 64'd0);
    chk("ovf_before", 64'(ovf_err), 64'd0);
    send(2'd1, CH_REQ, 32'hC100_0004);
    chk("ovf_set", 64'(ovf_err), 64'd1);
    chk("ovf_cc1_still", 64'(cc(1)), 64'd0);
    out_ready = 1'b1;
    chk("ovf_d0_flit", 64'(out_flit), 64'hC000_0000);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("ovf_d_flit", 64'(out_flit), 64'hC100_0000 + 64'(i));
      tick();
    end
    chk("ovf_drained", 64'(out_valid), 64'd0);
    chk("ovf_credits", 64'(credits), 64'd5);
    chk("ovf_sticky", 64'(ovf_err), 64'd1);
    chk("ovf_no_type", 64'(type_err), 64'd0);

    // Wrong channel type is dropped silently apart from type_err.
    credits = 0;
    send(2'd3, CH_DAT, 32'hD000_0000);
    chk("type_set", 64'(type_err), 64'd1);
    chk("type_cc3", 64'(cc(3)), 64'd4);
    tick();
    chk("type_no_out", 64'(out_valid), 64'd0);
    chk("type_no_credit", 64'(credits), 64'd0);

    // Stall: ready 1,0,0,1 with output held stable and no pops while stalled.
    out_ready = 1'b0; credits = 0;
    for (int i = 0; i < 3; i++) send(2'd2, CH_REQ, 32'hE000_0000 + 32'(i));
    chk("st_flit0", 64'(out_flit), 64'hE000_0000);
    chk("st_cc2_a", 64'(cc(2)), 64'd2);
    out_ready = 1'b1; tick();
    chk("st_flit1", 64'(out_flit), 64'hE000_0001);
    chk("st_credit1", 64'(credit_return), 64'b0100);
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("st_hold_flit", 64'(out_flit), 64'hE000_0001);
      chk("st_hold_valid", 64'(out_valid), 64'd1);
      chk("st_hold_credit", 64'(credit_return), 64'd0);
      chk("st_hold_cc2", 64'(cc(2)), 64'd3);
    end
    out_ready = 1'b1; tick();
    chk("st_flit2", 64'(out_flit), 64'hE000_0002);
    chk("st_credit2", 64'(credit_return), 64'b0100);
    chk("st_cc2_b", 64'(cc(2)), 64'd4);
    tick();
    chk("st_drained", 64'(out_valid), 64'd0);

    // Reset with flits buffered discards them without credits.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(2'd1, CH_REQ, 32'hF000_0000 + 32'(i));
    chk("mr_cc1", 64'(cc(1)), 64'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mr_valid", 64'(out_valid), 64'd0);
    chk("mr_credit_count", 64'(credit_count), 64'h924);
    chk("mr_credit_return", 64'(credit_return), 64'd0);
    chk("mr_errs", {62'd0, ovf_err, type_err}, 64'd0);
    credits = 0; out_ready = 1'b1;
    tick(); tick();
    chk("mr_after_valid", 64'(out_valid), 64'd0);
    chk("mr_after_credits", 64'(credits), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
